// File: rtl/dsd_if.sv
// DSD-in / PCM-out bundle for the CIC decimator.
// The master drives the 1-bit stream and receives PCM; the slave is the decimator.
interface dsd_if #(
    parameter int OUT_W = 16
);
    logic             din;
    logic             din_en;
    logic [OUT_W-1:0] pcm;
    logic             pcm_valid;
    logic             pcm_sat;

    modport master (
        output din,
        output din_en,
        input  pcm,
        input  pcm_valid,
        input  pcm_sat
    );

    modport slave (
        input  din,
        input  din_en,
        output pcm,
        output pcm_valid,
        output pcm_sat
    );
endinterface

// File: rtl/dsd_decimator.sv
// Pipelined CIC (Hogenauer) decimator: 1-bit DSD (+/-1) in, signed OUT_W PCM out.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_PRIME | comb delay lines settling; first ORDER ticks give no strobe
//   ST_RUN   | every tick yields one pcm_valid strobe, clipped to OUT_W
module dsd_decimator #(
    parameter int ORDER      = 3,
    parameter int DECIM_LOG2 = 8,
    parameter int OUT_W      = 16
) (
    input  logic  clk,
    input  logic  rst,
    dsd_if.slave  bus
);
    localparam int W  = ORDER * DECIM_LOG2 + 2;
    localparam int SH = ORDER * DECIM_LOG2 - (OUT_W - 1);
    localparam int R  = 1 << DECIM_LOG2;
    localparam int PW = $clog2(ORDER + 1);

    localparam logic signed [W-1:0] Y_MAX   = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] Y_MIN   = ~Y_MAX;
    localparam logic [OUT_W-1:0]    PCM_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]    PCM_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    if (ORDER < 1 || ORDER > 5) begin : g_bad_order
        $error("dsd_decimator: ORDER must be in 1..5");
    end
    if (SH < 0) begin : g_bad_shift
        $error("dsd_decimator: ORDER*DECIM_LOG2 must be >= OUT_W-1");
    end
    if (R < ORDER + 3) begin : g_bad_ratio
        $error("dsd_decimator: decimation ratio must be >= ORDER+3");
    end

    typedef enum logic [0:0] {
        ST_PRIME,
        ST_RUN
    } state_t;

    // integrator section (runs on accepted bits only)
    logic [W-1:0]          integ_q [ORDER];
    logic [W-1:0]          integ_d [ORDER];
    logic [W-1:0]          integ_src [ORDER];
    logic [W-1:0]          x_ext;
    logic [DECIM_LOG2-1:0] cnt_q;
    logic [DECIM_LOG2-1:0] cnt_d;
    logic                  tick;

    // comb section (runs on the tick pipeline only)
    logic [ORDER+1:0]      pipe_q;
    logic [W-1:0]          cap_q;
    logic [W-1:0]          comb_q  [ORDER];
    logic [W-1:0]          dly_q   [ORDER];
    logic [W-1:0]          comb_in [ORDER];

    // output stage
    state_t                state_q, state_d;
    logic [PW-1:0]         prime_q, prime_d;
    logic [OUT_W-1:0]      pcm_q, pcm_d;
    logic                  sat_q, sat_d;
    logic                  valid_q, valid_d;
    logic                  fire;
    logic signed [W-1:0]   y;
    logic [OUT_W-1:0]      clip_pcm;
    logic                  clip_sat;

    always_comb begin
        x_ext = bus.din ? W'(1) : {W{1'b1}};
        tick  = bus.din_en && (cnt_q == DECIM_LOG2'(R - 1));
        cnt_d = bus.din_en ? cnt_q + DECIM_LOG2'(1) : cnt_q;

        // Each stage adds the registered previous stage, so the chain is pipelined.
        integ_src[0] = x_ext;
        for (int k = 1; k < ORDER; k++) begin
            integ_src[k] = integ_q[k-1];
        end
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
            if (bus.din_en) begin
                integ_d[k] = integ_q[k] + integ_src[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
        end
    end

    always_comb begin
        comb_in[0] = cap_q;
        for (int k = 1; k < ORDER; k++) begin
            comb_in[k] = comb_q[k-1];
        end
    end

    // pipe_q[0] captures I_ORDER, pipe_q[k+1] fires comb k, pipe_q[ORDER+1] the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
            cap_q  <= '0;
            for (int k = 0; k < ORDER; k++) begin
                comb_q[k] <= '0;
                dly_q[k]  <= '0;
            end
        end else begin
            pipe_q <= {pipe_q[ORDER:0], tick};
            if (pipe_q[0]) begin
                cap_q <= integ_q[ORDER-1];
            end
            for (int k = 0; k < ORDER; k++) begin
                if (pipe_q[k+1]) begin
                    comb_q[k] <= comb_in[k] - dly_q[k];
                    dly_q[k]  <= comb_in[k];
                end
            end
        end
    end

    always_comb begin
        y        = $signed(comb_q[ORDER-1]) >>> SH;
        clip_pcm = y[OUT_W-1:0];
        clip_sat = 1'b0;
        if (y > Y_MAX) begin
            clip_pcm = PCM_MAX;
            clip_sat = 1'b1;
        end else if (y < Y_MIN) begin
            clip_pcm = PCM_MIN;
            clip_sat = 1'b1;
        end
    end

    always_comb begin
        fire    = pipe_q[ORDER+1];
        state_d = state_q;
        prime_d = prime_q;
        pcm_d   = pcm_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        case (state_q)
            ST_PRIME: begin
                if (fire) begin
                    prime_d = prime_q + PW'(1);
                    if (prime_q == PW'(ORDER - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fire) begin
                    valid_d = 1'b1;
                    pcm_d   = clip_pcm;
                    sat_d   = clip_sat;
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PRIME;
            prime_q <= '0;
            pcm_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
            pcm_q   <= pcm_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign bus.pcm       = pcm_q;
    assign bus.pcm_valid = valid_q;
    // The clip flag is only meaningful alongside its strobe.
    assign bus.pcm_sat   = sat_q & valid_q;
endmodule
